// File: rtl/conv_sequencer.sv
// Sequencer for the convolution/pooling datapath: loads packed weights per filter,
// runs mapping and conv, counts output pixels on flag edges, and waits for pooling.
module conv_sequencer #(
   parameter int COL      = 32,
   parameter int W_SETTLE = 13,
   parameter int MAP_LAT  = 163,
   parameter int PIX_W    = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_go,
   input  logic [4:0]       weight_dim,
   input  logic [5:0]       num_filter,
   input  logic [PIX_W-1:0] out_pixels,
   input  logic [31:0]      s_wdata,
   input  logic             s_wvalid,
   output logic             s_wready,
   output logic [31:0]      weight_in,
   output logic [COL-1:0]   weight_en,
   output logic             start,
   output logic             conv_ctrl,
   output logic             fifo_en,
   input  logic             flag,
   input  logic [COL-1:0]   pooling_finish,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int TMR_W = $clog2((MAP_LAT > W_SETTLE) ? MAP_LAT : W_SETTLE) + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SETTLE, S_MAP, S_CONV, S_DRAIN, S_DONE
   } state_t;

   state_t             state;
   logic [4:0]         nw_q;
   logic [5:0]         nf_q;
   logic [PIX_W-1:0]   npix_q;
   logic [COL-1:0]     mask_q;
   logic [5:0]         f_q;
   logic [4:0]         wcnt;
   logic [TMR_W-1:0]   tmr;
   logic [PIX_W-1:0]   pcnt;
   logic               flag_q;

   logic [4:0]         nw_calc;
   logic               cfg_bad;
   logic               pool_ok;
   logic               flag_rise;

   function automatic logic [COL-1:0] onehot(input logic [5:0] idx);
      logic [COL-1:0] v;
      v = '0;
      for (int i = 0; i < COL; i++)
         if (i == int'(idx)) v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic [COL-1:0] low_mask(input logic [5:0] n);
      logic [COL-1:0] v;
      v = '0;
      for (int i = 0; i < COL; i++)
         if (i < int'(n)) v[i] = 1'b1;
      return v;
   endfunction

   // ceil(weight_dim/2) without needing a sixth bit
   assign nw_calc   = {1'b0, weight_dim[4:1]} + {4'b0, weight_dim[0]};
   assign cfg_bad   = (num_filter == 6'd0) || (int'(num_filter) > COL) ||
                      (weight_dim == 5'd0) || (out_pixels == '0);
   assign pool_ok   = &(pooling_finish | ~mask_q);
   assign flag_rise = flag && !flag_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         nw_q      <= '0;
         nf_q      <= '0;
         npix_q    <= '0;
         mask_q    <= '0;
         f_q       <= '0;
         wcnt      <= '0;
         tmr       <= '0;
         pcnt      <= '0;
         flag_q    <= 1'b0;
         s_wready  <= 1'b0;
         weight_in <= '0;
         weight_en <= '0;
         start     <= 1'b0;
         conv_ctrl <= 1'b0;
         fifo_en   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         // flag history runs in every state so a level held across states is one edge
         flag_q <= flag;
         err    <= 1'b0;
         done   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cfg_go) begin
                  if (cfg_bad) begin
                     err <= 1'b1;
                  end else begin
                     nw_q      <= nw_calc;
                     nf_q      <= num_filter;
                     npix_q    <= out_pixels;
                     mask_q    <= low_mask(num_filter);
                     f_q       <= '0;
                     wcnt      <= '0;
                     pcnt      <= '0;
                     weight_en <= onehot(6'd0);
                     s_wready  <= 1'b1;
                     busy      <= 1'b1;
                     state     <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               if (s_wvalid && s_wready) begin
                  weight_in <= s_wdata;
                  wcnt      <= wcnt + 5'd1;
                  if (wcnt + 5'd1 == nw_q) begin
                     s_wready <= 1'b0;
                     tmr      <= '0;
                     state    <= S_SETTLE;
                  end
               end
            end
            S_SETTLE: begin
               if (tmr == TMR_W'(W_SETTLE - 1)) begin
                  tmr <= '0;
                  if (f_q + 6'd1 < nf_q) begin
                     f_q       <= f_q + 6'd1;
                     wcnt      <= '0;
                     weight_en <= onehot(f_q + 6'd1);
                     s_wready  <= 1'b1;
                     state     <= S_LOAD;
                  end else begin
                     weight_en <= '0;
                     start     <= 1'b1;
                     state     <= S_MAP;
                  end
               end else begin
                  tmr <= tmr + TMR_W'(1);
               end
            end
            S_MAP: begin
               if (tmr == TMR_W'(MAP_LAT - 1)) begin
                  conv_ctrl <= 1'b1;
                  fifo_en   <= 1'b1;
                  state     <= S_CONV;
               end else begin
                  tmr <= tmr + TMR_W'(1);
               end
            end
            S_CONV: begin
               if (flag_rise) begin
                  pcnt <= pcnt + PIX_W'(1);
                  if (pcnt + PIX_W'(1) == npix_q) state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (pool_ok) begin
                  done      <= 1'b1;
                  start     <= 1'b0;
                  conv_ctrl <= 1'b0;
                  fifo_en   <= 1'b0;
                  state     <= S_DONE;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
